// File: rtl/dcache_lsu.sv
// Load/store front end for the data-cache AHB controller: in-order request FIFO, one outstanding request.
// Define DCACHE_LSU_MISALIGN_CHECK_EN to report misaligned accesses with cpu_err instead of aligning them.
module dcache_lsu #(
    parameter int ADDR_LENGTH = 32,
    parameter int WORD_SIZE   = 32,
    parameter int DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cpu_valid,
    output logic                   cpu_ready,
    input  logic [ADDR_LENGTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]   cpu_wdata,
    input  logic                   cpu_write,
    input  logic [1:0]             cpu_size,
    input  logic                   cpu_unsigned,
    output logic                   cpu_rvalid,
    output logic [WORD_SIZE-1:0]   cpu_rdata,
    output logic                   cpu_err,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic [ADDR_LENGTH-1:0] req_addr,
    output logic [WORD_SIZE-1:0]   req_wdata,
    output logic                   req_write,
    output logic [2:0]             req_size,
    input  logic                   resp_valid,
    input  logic [WORD_SIZE-1:0]   resp_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = lsb[0];
            default: mis = (lsb != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [WORD_SIZE-1:0] replicate_lanes(input logic [1:0] size,
                                                            input logic [WORD_SIZE-1:0] data);
        logic [WORD_SIZE-1:0] rep;
        case (size)
            2'd0:    rep = {4{data[7:0]}};
            2'd1:    rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [WORD_SIZE-1:0] extract_load(input logic [WORD_SIZE-1:0] word,
                                                         input logic [1:0] lsb,
                                                         input logic [1:0] size,
                                                         input logic uns);
        logic [7:0]           b;
        logic [15:0]          h;
        logic [WORD_SIZE-1:0] res;
        b = word[{lsb, 3'b000} +: 8];
        h = word[{lsb[1], 4'b0000} +: 16];
        case (size)
            2'd0:    res = {{24{~uns & b[7]}}, b};
            2'd1:    res = {{16{~uns & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    logic [ADDR_LENGTH-1:0] addr_q_r  [DEPTH];
    logic [WORD_SIZE-1:0]   wdata_q_r [DEPTH];
    logic                   write_q_r [DEPTH];
    logic [1:0]             size_q_r  [DEPTH];
    logic                   uns_q_r   [DEPTH];
    logic                   mis_q_r   [DEPTH];
    logic [PW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]          count_r;
    state_t                 state_r, state_nxt_s;

    logic                   push_s, pop_s, enq_mis_s;
    logic                   done_s, done_err_s;
    logic [WORD_SIZE-1:0]   done_data_s;
    logic                   rvalid_r, err_r;
    logic [WORD_SIZE-1:0]   rdata_r;

    logic [ADDR_LENGTH-1:0] head_addr_s, eff_addr_s;
    logic [WORD_SIZE-1:0]   head_wdata_s;
    logic                   head_write_s, head_uns_s, head_mis_s;
    logic [1:0]             head_size_s;

    assign head_addr_s  = addr_q_r[rd_ptr_r];
    assign head_wdata_s = wdata_q_r[rd_ptr_r];
    assign head_write_s = write_q_r[rd_ptr_r];
    assign head_size_s  = size_q_r[rd_ptr_r];
    assign head_uns_s   = uns_q_r[rd_ptr_r];
    assign head_mis_s   = mis_q_r[rd_ptr_r];

    assign cpu_ready = (count_r != CW'(DEPTH));
    assign push_s    = cpu_valid && cpu_ready;

`ifdef DCACHE_LSU_MISALIGN_CHECK_EN
    assign enq_mis_s  = is_misaligned(cpu_size, cpu_addr[1:0]);
    assign eff_addr_s = head_addr_s;
`else
    assign enq_mis_s  = 1'b0;
    // Without the check, misaligned halves and words are silently aligned down
    always_comb begin
        eff_addr_s = head_addr_s;
        case (head_size_s)
            2'd0:    eff_addr_s = head_addr_s;
            2'd1:    eff_addr_s = {head_addr_s[ADDR_LENGTH-1:1], 1'b0};
            default: eff_addr_s = {head_addr_s[ADDR_LENGTH-1:2], 2'b00};
        endcase
    end
`endif

    // Request FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q_r[i]  <= '0;
                wdata_q_r[i] <= '0;
                write_q_r[i] <= 1'b0;
                size_q_r[i]  <= 2'd0;
                uns_q_r[i]   <= 1'b0;
                mis_q_r[i]   <= 1'b0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                addr_q_r[wr_ptr_r]  <= cpu_addr;
                wdata_q_r[wr_ptr_r] <= cpu_wdata;
                write_q_r[wr_ptr_r] <= cpu_write;
                size_q_r[wr_ptr_r]  <= cpu_size;
                uns_q_r[wr_ptr_r]   <= cpu_unsigned;
                mis_q_r[wr_ptr_r]   <= enq_mis_s;
                wr_ptr_r            <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Issue FSM: next state, FIFO pop and completion generation
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        done_s      = 1'b0;
        done_err_s  = 1'b0;
        done_data_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != '0) begin
                    if (head_mis_s) begin
                        pop_s       = 1'b1;
                        done_s      = 1'b1;
                        done_err_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (req_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // Write misses come back via req_ready only, never resp_valid
                if (resp_valid || (req_ready && head_write_s)) begin
                    pop_s       = 1'b1;
                    done_s      = 1'b1;
                    done_data_s = head_write_s ? '0
                                : extract_load(resp_rdata, eff_addr_s[1:0], head_size_s, head_uns_s);
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered completion toward the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            rvalid_r <= done_s;
            rdata_r  <= done_s ? done_data_s : '0;
            err_r    <= done_s && done_err_s;
        end
    end

    assign cpu_rvalid = rvalid_r;
    assign cpu_rdata  = rdata_r;
    assign cpu_err    = err_r;

    assign req_valid = (state_r == ST_ISSUE);
    assign req_addr  = req_valid ? eff_addr_s : '0;
    assign req_wdata = req_valid ? replicate_lanes(head_size_s, head_wdata_s) : '0;
    assign req_write = req_valid && head_write_s;
    assign req_size  = req_valid ? {1'b0, head_size_s} : 3'b000;

endmodule

// File: tb/tb_dcache_lsu.sv
// Scoreboard bench for dcache_lsu: stimulus pushes expected completions, a negedge monitor pops and compares.
module tb_dcache_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid, cpu_ready, cpu_write, cpu_unsigned;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_rvalid, cpu_err;
    logic [31:0] cpu_rdata;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    dcache_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_write(cpu_write), .cpu_size(cpu_size),
        .cpu_unsigned(cpu_unsigned), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .req_size(req_size), .resp_valid(resp_valid), .resp_rdata(resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] wd, input logic w,
                            input logic [1:0] s, input logic u, input bit track,
                            input logic [31:0] ed, input logic ee);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!cpu_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            timeout_fail("push_ready");
            return;
        end
        cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd;
        cpu_write = w; cpu_size = s; cpu_unsigned = u;
        if (track) begin
            e.data = ed;
            e.err  = ee;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 cpu_valid = 1'b0;
    endtask

    task automatic issue_accept(input logic [31:0] ea, input logic [31:0] ewd,
                                input logic [2:0] es, input int stall);
        int n = 0;
        @(negedge clk);
        while (!req_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            timeout_fail("req_valid_wait");
            return;
        end
        chk("req_addr", req_addr, ea);
        chk("req_wdata", req_wdata, ewd);
        chk("req_size", {29'd0, req_size}, {29'd0, es});
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            chk("req_addr_held", req_addr, ea);
        end
        req_ready = 1'b1;
        @(posedge clk);
        #1 req_ready = 1'b0;
    endtask

    task automatic respond_load(input logic [31:0] d);
        resp_rdata = d;
        resp_valid = 1'b1;
        @(posedge clk);
        #1 resp_valid = 1'b0;
        resp_rdata = 32'd0;
    endtask

    task automatic respond_store();
        req_ready = 1'b1;
        @(posedge clk);
        #1 req_ready = 1'b0;
    endtask

    // Monitor: scoreboard pop on every completion, plus req_valid spacing
    initial begin
        int  low_cnt = 0;
        bit  seen_pulse = 1'b0;
        bit  prev_high = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_rvalid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rvalid: rdata 0x%08h err %0b with empty scoreboard",
                             cpu_rdata, cpu_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("cpu_rdata", cpu_rdata, e.data);
                    chk("cpu_err", {31'd0, cpu_err}, {31'd0, e.err});
                end
            end
            if (!rst_n) begin
                seen_pulse = 1'b0;
                low_cnt    = 0;
            end else if (req_valid) begin
                if (!prev_high && seen_pulse) chk("req_spacing_ge2", {31'd0, low_cnt >= 2}, 32'd1);
                seen_pulse = 1'b1;
                low_cnt    = 0;
            end else begin
                low_cnt++;
            end
            prev_high = req_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; cpu_valid = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        cpu_write = 1'b0; cpu_size = 2'd0; cpu_unsigned = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_req_addr", req_addr, 32'd0);
        rst_n = 1'b1;

        // Word load hit
        push_req(32'h100, 32'd0, 1'b0, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        issue_accept(32'h100, 32'd0, 3'd2, 0);
        respond_load(32'hDEADBEEF);

        // Signed and unsigned byte loads from lane 3
        push_req(32'h103, 32'd0, 1'b0, 2'd0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0);
        issue_accept(32'h103, 32'd0, 3'd0, 0);
        respond_load(32'h80123456);
        push_req(32'h103, 32'd0, 1'b0, 2'd0, 1'b1, 1'b1, 32'h00000080, 1'b0);
        issue_accept(32'h103, 32'd0, 3'd0, 0);
        respond_load(32'h80123456);

        // Stores complete through req_ready with no resp_valid
        push_req(32'h202, 32'h0000ABCD, 1'b1, 2'd1, 1'b0, 1'b1, 32'd0, 1'b0);
        issue_accept(32'h202, 32'hABCDABCD, 3'd1, 0);
        respond_store();
        push_req(32'h201, 32'h12345678, 1'b1, 2'd0, 1'b0, 1'b1, 32'd0, 1'b0);
        issue_accept(32'h201, 32'h78787878, 3'd0, 0);
        respond_store();

        // Fill the FIFO while the cache stalls
        push_req(32'h300, 32'd0, 1'b0, 2'd2, 1'b0, 1'b1, 32'h11223344, 1'b0);
        push_req(32'h306, 32'd0, 1'b0, 2'd1, 1'b0, 1'b1, 32'hFFFFCAFE, 1'b0);
        @(negedge clk);
        chk("full_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        issue_accept(32'h300, 32'd0, 3'd2, 5);
        respond_load(32'h11223344);
        issue_accept(32'h306, 32'd0, 3'd1, 0);
        respond_load(32'hCAFE1234);

`ifdef DCACHE_LSU_MISALIGN_CHECK_EN
        push_req(32'h101, 32'd0, 1'b0, 2'd2, 1'b0, 1'b1, 32'd0, 1'b1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (req_valid) seen = 1'b1;
        end
        chk("mis_no_req_valid", {31'd0, seen}, 32'd0);
        push_req(32'h104, 32'd0, 1'b0, 2'd2, 1'b0, 1'b1, 32'h55AA55AA, 1'b0);
        issue_accept(32'h104, 32'd0, 3'd2, 0);
        respond_load(32'h55AA55AA);
`else
        push_req(32'h101, 32'd0, 1'b0, 2'd2, 1'b0, 1'b1, 32'h01020304, 1'b0);
        issue_accept(32'h100, 32'd0, 3'd2, 0);
        respond_load(32'h01020304);
        push_req(32'h203, 32'd0, 1'b0, 2'd1, 1'b0, 1'b1, 32'hFFFF8001, 1'b0);
        issue_accept(32'h202, 32'd0, 3'd1, 0);
        respond_load(32'h8001FFFF);
`endif

        // Reset while waiting with a second entry queued: nothing may complete
        push_req(32'h400, 32'd0, 1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 1'b0);
        issue_accept(32'h400, 32'd0, 3'd2, 0);
        push_req(32'h404, 32'd0, 1'b0, 2'd2, 1'b0, 1'b0, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_mid_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("rst_mid_cpu_ready", {31'd0, cpu_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (req_valid) seen = 1'b1;
        end
        chk("post_rst_no_req", {31'd0, seen}, 32'd0);
        chk("post_rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
